// File: rtl/hazard_stall_unit_pkg.sv
// Shared CPU package: register constants and the in-flight writer scoreboard entry.
package hazard_stall_unit_pkg;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{v: 1'b0, rd: REG_X0};

  // A valid entry targeting x0 never produces a value anyone can wait on.
  function automatic logic sb_is_writer(input logic v, input logic [4:0] rd);
    return v & (rd != REG_X0);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_sb_match.sv
// Compares one ID source register against one scoreboard entry.
module sb_match
  import hazard_stall_unit_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic       used_i,
  input  logic       ent_v_i,
  input  logic [4:0] ent_rd_i,
  output logic       hit_o
);

  assign hit_o = used_i & (rs_i != REG_X0) & sb_is_writer(ent_v_i, ent_rd_i)
               & (rs_i == ent_rd_i);

endmodule

// File: rtl/hazard_stall_unit.sv
// RAW interlock for the stall-only five-stage pipeline: tracks EX/MEM writers,
// drives hold/flush/bubble controls and counts interlock stall cycles.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             Rs1_used,
  input  logic             Rs2_used,
  input  logic             RegWrite,
  input  logic             ex_redirect,
  input  logic             MIO_ready,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             bubble_idex,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  sb_entry_t        ex_q, ex_d, mem_q, mem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit1_ex, hit1_mem, hit2_ex, hit2_mem;
  logic             haz;

  sb_match u_rs1_ex  (.rs_i(id_rs1), .used_i(Rs1_used), .ent_v_i(ex_q.v),
                      .ent_rd_i(ex_q.rd),  .hit_o(hit1_ex));
  sb_match u_rs1_mem (.rs_i(id_rs1), .used_i(Rs1_used), .ent_v_i(mem_q.v),
                      .ent_rd_i(mem_q.rd), .hit_o(hit1_mem));
  sb_match u_rs2_ex  (.rs_i(id_rs2), .used_i(Rs2_used), .ent_v_i(ex_q.v),
                      .ent_rd_i(ex_q.rd),  .hit_o(hit2_ex));
  sb_match u_rs2_mem (.rs_i(id_rs2), .used_i(Rs2_used), .ent_v_i(mem_q.v),
                      .ent_rd_i(mem_q.rd), .hit_o(hit2_mem));

  assign haz = id_valid & (hit1_ex | hit1_mem | hit2_ex | hit2_mem);

  // Control priority: memory freeze, then redirect, then interlock, then issue.
  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    ex_d        = ex_q;
    mem_d       = mem_q;
    cnt_d       = cnt_q;
    if (!MIO_ready) begin
      stall_pc   = 1'b1;
      stall_ifid = 1'b1;
    end else if (ex_redirect) begin
      flush_ifid  = 1'b1;
      bubble_idex = 1'b1;
      mem_d       = ex_q;
      ex_d        = SB_EMPTY;
    end else if (haz) begin
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      bubble_idex = 1'b1;
      mem_d       = ex_q;
      ex_d        = SB_EMPTY;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      mem_d = ex_q;
      ex_d  = '{v: id_valid & RegWrite, rd: id_rd};
    end
  end

  // Scoreboard and stall counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= SB_EMPTY;
      mem_q <= SB_EMPTY;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule
